// File: rtl/axi_stream_extract_header_pkg.sv
// Shared types and keep/count helpers for the header insert/extract stages.
package axi_stream_extract_header_pkg;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

  // Count of contiguous ones from bit nb-1 downward (MSB-aligned keep).
  function automatic int keep2cnt(input logic [MAX_BYTES-1:0] keep, input int nb);
    int   c;
    logic run;
    c   = 0;
    run = 1'b1;
    for (int i = MAX_BYTES-1; i >= 0; i--) begin
      if (i < nb) begin
        if (run && keep[i]) c++;
        else run = 1'b0;
      end
    end
    return c;
  endfunction

  // Mask with the low cnt bits set.
  function automatic logic [MAX_BYTES-1:0] cnt2keep(input int cnt);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (i < cnt) m[i] = 1'b1;
    return m;
  endfunction

  // Mask with the top cnt bits of an nb-wide keep set.
  function automatic logic [MAX_BYTES-1:0] msbkeep(input int cnt, input int nb);
    return cnt2keep(nb) & ~cnt2keep(nb - cnt);
  endfunction

endpackage

// File: rtl/axi_stream_extract_header_if.sv
// AXI-Stream bundle used for the input, payload and header ports.
interface axi_stream_extract_header_if #(
  parameter int DATA_WD = 32
) ();
  localparam int KEEP_WD = DATA_WD / 8;

  logic               valid;
  logic               ready;
  logic [DATA_WD-1:0] data;
  logic [KEEP_WD-1:0] keep;
  logic               last;

  modport master (output valid, data, keep, last, input  ready);
  modport slave  (input  valid, data, keep, last, output ready);
endinterface

// File: rtl/axi_stream_extract_header_axis_reg_slice.sv
// Single-entry output register: loads on push, holds while stalled.
module axis_reg_slice #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic [KW-1:0] i_keep,
  input  logic          i_last,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [KW-1:0] o_keep,
  output logic          o_last
);
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [KW-1:0] r_keep;
  logic          r_last;

  // Push only happens when the slot is free; otherwise drain on ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_last  = r_last;
endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips the first N bytes of each packet onto a header port and
// re-aligns the remaining payload to full MSB-first beats.
module axi_stream_extract_header
  import axi_stream_extract_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid_cfg,
  input  logic [CNT_WD-1:0]     i_byte_extract_cnt,
  output logic                  o_ready_cfg,
  output logic                  o_err_short,
  axi_stream_extract_header_if.slave  s_axis,
  axi_stream_extract_header_if.master m_axis,
  axi_stream_extract_header_if.master m_hdr
);
  localparam int W = DATA_BYTE_WD;

  state_t              r_state, w_state_nxt;
  logic [CNT_WD-1:0]   r_s, r_r, w_r_nxt;
  logic [DATA_WD-1:0]  r_res, w_res_nxt;
  logic                r_err, w_err_nxt, w_res_ld;
  logic                w_ready_in, w_out_free, w_hdr_free;
  logic                w_out_push, w_out_last, w_hdr_push;
  logic [DATA_WD-1:0]  w_out_data, w_hdr_data;
  logic [W-1:0]        w_out_keep, w_hdr_keep;
  int                  w_k, w_s, w_r;

  assign w_out_free = ~m_axis.valid | m_axis.ready;
  assign w_hdr_free = ~m_hdr.valid | m_hdr.ready;

  // State, config count, residue and short-packet pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_r     <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_r     <= w_r_nxt;
      r_err   <= w_err_nxt;
      if (w_res_ld) r_res <= w_res_nxt;
      if (o_ready_cfg && i_valid_cfg)
        r_s <= (int'(i_byte_extract_cnt) > W) ? CNT_WD'(W) : i_byte_extract_cnt;
    end
  end

  // Next state, handshakes and the beat to load into each output slot.
  always_comb begin
    w_state_nxt = r_state;
    o_ready_cfg = 1'b0;
    w_ready_in  = 1'b0;
    w_k         = keep2cnt(MAX_BYTES'(s_axis.keep), W);
    w_s         = int'(r_s);
    w_r         = int'(r_r);
    w_out_push  = 1'b0;
    w_out_data  = s_axis.data;
    w_out_keep  = '1;
    w_out_last  = 1'b0;
    w_hdr_push  = 1'b0;
    w_hdr_data  = s_axis.data >> ((W - w_s) * 8);
    w_hdr_keep  = W'(cnt2keep(w_s));
    w_res_ld    = 1'b0;
    w_res_nxt   = s_axis.data << (w_s * 8);
    w_r_nxt     = r_r;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready_cfg = 1'b1;
        if (i_valid_cfg) w_state_nxt = FIRST;
      end
      FIRST: begin
        w_ready_in = w_hdr_free & w_out_free;
        if (s_axis.valid && w_ready_in) begin
          w_hdr_push = (w_s != 0);
          w_hdr_keep = W'(cnt2keep((s_axis.last && w_k < w_s) ? w_k : w_s));
          w_res_ld   = 1'b1;
          // S=0 keeps no residue: the beat goes straight through.
          if (w_s == 0) w_res_nxt = '0;
          w_r_nxt    = (w_s == 0) ? '0 : CNT_WD'(W - w_s);
          if (s_axis.last) begin
            w_err_nxt   = (w_k < w_s);
            w_state_nxt = IDLE;
            w_r_nxt     = '0;
            if (w_k > w_s) begin
              w_out_push = 1'b1;
              w_out_data = s_axis.data << (w_s * 8);
              w_out_keep = W'(msbkeep(w_k - w_s, W));
              w_out_last = 1'b1;
            end
          end else begin
            w_out_push  = (w_s == 0);
            w_state_nxt = BODY;
          end
        end
      end
      BODY: begin
        w_ready_in = w_out_free;
        if (s_axis.valid && w_ready_in) begin
          w_out_push = 1'b1;
          w_out_data = r_res | (s_axis.data >> (w_r * 8));
          w_res_ld   = 1'b1;
          w_res_nxt  = s_axis.data << ((W - w_r) * 8);
          if (s_axis.last) begin
            if (w_k <= W - w_r) begin
              w_out_keep  = W'(msbkeep(w_r + w_k, W));
              w_out_last  = 1'b1;
              w_r_nxt     = '0;
              w_state_nxt = IDLE;
            end else begin
              w_r_nxt     = CNT_WD'(w_k - (W - w_r));
              w_state_nxt = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (w_out_free) begin
          w_out_push  = 1'b1;
          w_out_data  = r_res;
          w_out_keep  = W'(msbkeep(w_r, W));
          w_out_last  = 1'b1;
          w_r_nxt     = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign s_axis.ready = w_ready_in;
  assign o_err_short  = r_err;

  axis_reg_slice #(.DW(DATA_WD), .KW(W)) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_out_push),
    .i_data  (w_out_data),
    .i_keep  (w_out_keep),
    .i_last  (w_out_last),
    .i_ready (m_axis.ready),
    .o_valid (m_axis.valid),
    .o_data  (m_axis.data),
    .o_keep  (m_axis.keep),
    .o_last  (m_axis.last)
  );

  axis_reg_slice #(.DW(DATA_WD), .KW(W)) u_hdr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_hdr_push),
    .i_data  (w_hdr_data),
    .i_keep  (w_hdr_keep),
    .i_last  (1'b1),
    .i_ready (m_hdr.ready),
    .o_valid (m_hdr.valid),
    .o_data  (m_hdr.data),
    .o_keep  (m_hdr.keep),
    .o_last  (m_hdr.last)
  );
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed and randomized checks for axi_stream_extract_header (W=4 bytes).
module tb_axi_stream_extract_header;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid_cfg = 1'b0;
  logic [CW-1:0] cnt = '0;
  logic          ready_cfg, err_short;

  axi_stream_extract_header_if #(.DATA_WD(DW)) s_in  ();
  axi_stream_extract_header_if #(.DATA_WD(DW)) m_out ();
  axi_stream_extract_header_if #(.DATA_WD(DW)) m_hdr ();

  axi_stream_extract_header #(.DATA_WD(DW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_valid_cfg        (valid_cfg),
    .i_byte_extract_cnt (cnt),
    .o_ready_cfg        (ready_cfg),
    .o_err_short        (err_short),
    .s_axis             (s_in),
    .m_axis             (m_out),
    .m_hdr              (m_hdr)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  beat_t exp_out[$];
  beat_t exp_hdr[$];

  int total = 0, bad = 0, err_seen = 0, err_exp = 0;
  bit mon_en = 1'b0, bp_en = 1'b0;
  logic out_rdy = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{k[j]}};
    return m;
  endfunction

  task automatic eo(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_out.push_back('{d: d, k: k, l: l});
  endtask

  task automatic eh(input logic [31:0] d, input logic [3:0] k);
    exp_hdr.push_back('{d: d, k: k, l: 1'b1});
  endtask

  // Ready generator: random under backpressure, directed otherwise.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      m_out.ready = ($urandom_range(0, 3) != 0);
      m_hdr.ready = ($urandom_range(0, 2) != 0);
    end else begin
      m_out.ready = out_rdy;
      m_hdr.ready = 1'b1;
    end
  end

  // Output monitor: scoreboard compare on handshake, hold check on stall.
  logic        p_ov = 1'b0, p_or = 1'b0, p_hv = 1'b0, p_hr = 1'b0;
  logic [36:0] p_o = '0;
  logic [35:0] p_h = '0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n || !mon_en) begin
      p_ov <= 1'b0;
      p_hv <= 1'b0;
    end else begin
      if (p_ov && !p_or)
        chk("out_hold", 64'({m_out.valid, m_out.data, m_out.keep, m_out.last}), 64'({1'b1, p_o}));
      if (p_hv && !p_hr)
        chk("hdr_hold", 64'({m_hdr.valid, m_hdr.data, m_hdr.keep}), 64'({1'b1, p_h}));
      if (m_out.valid && m_out.ready) begin
        chk("out_expected", 64'(exp_out.size() > 0), 64'(1));
        if (exp_out.size() > 0) begin
          e = exp_out.pop_front();
          chk("out_data", 64'(m_out.data & kmask(e.k)), 64'(e.d & kmask(e.k)));
          chk("out_keep", 64'(m_out.keep), 64'(e.k));
          chk("out_last", 64'(m_out.last), 64'(e.l));
        end
      end
      if (m_hdr.valid && m_hdr.ready) begin
        chk("hdr_expected", 64'(exp_hdr.size() > 0), 64'(1));
        if (exp_hdr.size() > 0) begin
          e = exp_hdr.pop_front();
          chk("hdr_data", 64'(m_hdr.data), 64'(e.d));
          chk("hdr_keep", 64'(m_hdr.keep), 64'(e.k));
        end
      end
      if (err_short) err_seen <= err_seen + 1;
      p_ov <= m_out.valid;
      p_or <= m_out.ready;
      p_o  <= {m_out.data, m_out.keep, m_out.last};
      p_hv <= m_hdr.valid;
      p_hr <= m_hdr.ready;
      p_h  <= {m_hdr.data, m_hdr.keep};
    end
  end

  task automatic send_cfg(input logic [CW-1:0] n);
    int c = 0;
    valid_cfg = 1'b1;
    cnt = n;
    while (!ready_cfg && c < 1000) begin @(negedge clk); c++; end
    chk("cfg_handshake", 64'(ready_cfg), 64'(1));
    @(negedge clk);
    valid_cfg = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int c = 0;
    s_in.valid = 1'b1;
    s_in.data  = d;
    s_in.keep  = k;
    s_in.last  = l;
    while (!s_in.ready && c < 1000) begin @(negedge clk); c++; end
    chk("in_handshake", 64'(s_in.ready), 64'(1));
    @(negedge clk);
    s_in.valid = 1'b0;
  endtask

  task automatic drain;
    int c = 0;
    while ((exp_out.size() + exp_hdr.size()) != 0 && c < 1000) begin @(negedge clk); c++; end
    chk("drain", 64'(exp_out.size() + exp_hdr.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  // One random packet; expectations come from a byte-level view of it.
  task automatic rand_pkt;
    int n, s, len, m;
    logic [7:0]  b[$];
    logic [31:0] d;
    logic [3:0]  k;
    n   = $urandom_range(0, 6);
    s   = (n > 4) ? 4 : n;
    len = $urandom_range(1, 14);
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    if (s > 0) begin
      d = '0;
      for (int i = 0; i < s; i++) d[8*(s-1-i) +: 8] = (i < len) ? b[i] : 8'h00;
      m = (len < s) ? len : s;
      eh(d, 4'((1 << m) - 1));
    end
    if (len < s) err_exp++;
    for (int p = s; p < len; p += 4) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++)
        if (p + j < len) begin d[8*(3-j) +: 8] = b[p+j]; k[3-j] = 1'b1; end
      eo(d, k, (p + 4 >= len));
    end
    send_cfg(CW'(n));
    for (int p = 0; p < len; p += 4) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++)
        if (p + j < len) begin d[8*(3-j) +: 8] = b[p+j]; k[3-j] = 1'b1; end
      send_beat(d, k, (p + 4 >= len));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_in.valid = 1'b0;
    s_in.data  = '0;
    s_in.keep  = '0;
    s_in.last  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid_out", 64'(m_out.valid), 64'(0));
    chk("rst_valid_hdr", 64'(m_hdr.valid), 64'(0));
    chk("rst_err_short", 64'(err_short), 64'(0));
    chk("rst_ready_cfg", 64'(ready_cfg), 64'(1));
    chk("rst_ready_in",  64'(s_in.ready), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // N=2: three-beat packet, residue carried across beats.
    eh(32'h0000AABB, 4'b0011);
    eo(32'hCCDDEEFF, 4'b1111, 1'b0);
    eo(32'h00112233, 4'b1111, 1'b1);
    send_cfg(3'd2);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'hEEFF0011, 4'b1111, 1'b0);
    send_beat(32'h22330000, 4'b1100, 1'b1);
    chk("cfg_ready_after_last", 64'(ready_cfg), 64'(1));
    drain;

    // N=1: last beat overflows the output, leftover goes out via FLUSH.
    eh(32'h000000AA, 4'b0001);
    eo(32'hBBCCDD00, 4'b1111, 1'b0);
    eo(32'h11223344, 4'b1111, 1'b0);
    eo(32'h55667700, 4'b1110, 1'b1);
    send_cfg(3'd1);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'h00112233, 4'b1111, 1'b0);
    send_beat(32'h44556677, 4'b1111, 1'b1);
    chk("flush_ready_in",  64'(s_in.ready), 64'(0));
    chk("flush_ready_cfg", 64'(ready_cfg), 64'(0));
    drain;

    // N=3: packet ends inside the header.
    eh(32'h00AABBCC, 4'b0011);
    err_exp = 1;
    send_cfg(3'd3);
    send_beat(32'hAABBCCDD, 4'b1100, 1'b1);
    chk("short_err_pulse", 64'(err_short), 64'(1));
    @(negedge clk);
    chk("short_err_clear", 64'(err_short), 64'(0));
    drain;

    // N=0: pass-through, no header.
    eo(32'h01020304, 4'b1111, 1'b0);
    eo(32'h05060000, 4'b1100, 1'b1);
    send_cfg(3'd0);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060000, 4'b1100, 1'b1);
    drain;

    // N=4: whole first beat is header, rest passes through.
    eh(32'h11121314, 4'b1111);
    eo(32'h15161718, 4'b1111, 1'b0);
    eo(32'h191A0000, 4'b1000, 1'b1);
    send_cfg(3'd4);
    send_beat(32'h11121314, 4'b1111, 1'b0);
    send_beat(32'h15161718, 4'b1111, 1'b0);
    send_beat(32'h191A0000, 4'b1000, 1'b1);
    drain;

    // N=6 clamps to 4: single full beat is exactly the header.
    eh(32'h21222324, 4'b1111);
    send_cfg(3'd6);
    send_beat(32'h21222324, 4'b1111, 1'b1);
    drain;
    chk("err_count_directed", 64'(err_seen), 64'(err_exp));

    // Reset mid-BODY with a stalled payload beat pending.
    mon_en  = 1'b0;
    out_rdy = 1'b0;
    @(negedge clk);
    send_cfg(3'd2);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'hEEFF0011, 4'b1111, 1'b0);
    chk("pre_reset_valid_out", 64'(m_out.valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_out", 64'(m_out.valid), 64'(0));
    chk("mid_rst_valid_hdr", 64'(m_hdr.valid), 64'(0));
    chk("mid_rst_ready_cfg", 64'(ready_cfg), 64'(1));
    chk("mid_rst_ready_in",  64'(s_in.ready), 64'(0));
    @(posedge clk);
    #1;
    chk("mid_rst_edge_valid_out", 64'(m_out.valid), 64'(0));
    @(negedge clk);
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    exp_out.delete();
    exp_hdr.delete();
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Packet after reset must be clean.
    eh(32'h0000AABB, 4'b0011);
    eo(32'hCCDDEEFF, 4'b1111, 1'b0);
    eo(32'h00112233, 4'b1111, 1'b1);
    send_cfg(3'd2);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'hEEFF0011, 4'b1111, 1'b0);
    send_beat(32'h22330000, 4'b1100, 1'b1);
    drain;

    // Random packets under random backpressure on both output ports.
    bp_en = 1'b1;
    repeat (200) rand_pkt();
    drain;
    bp_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_count_total", 64'(err_seen), 64'(err_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
